key_debounce: RTL and testbench

Conditions the raw active-low push-buttons of the stopwatch board into clean, single-cycle control events. Each key is synchronised, debounced and classified into press, release and long-press pulses, and each key also drives a toggle level. The block sits directly upstream of the stopwatch counter: it feeds the clear and run/pause inputs, and its toggle output replaces the counter's ad-hoc flag/run logic.

---
 rtl/key_pkg.sv | 16 +
 rtl/key_debounce_ch.sv | 108 ++++++++++
 rtl/key_debounce.sv | 40 ++++
 tb/tb_key_debounce.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types and helpers for the key debounce block.
package key_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } key_state_e;

   function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                                input int unsigned ms);
      return (clk_hz / 1000) * ms;
   endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: two-flop synchroniser, debounce FSM, shared hold/debounce
// counter and registered press/release/long pulses plus toggle level.
module key_debounce_ch
   import key_pkg::*;
#(
   parameter int unsigned DEB_CYC  = 4,
   parameter int unsigned LONG_CYC = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic key_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse,
   output logic key_toggle
);

   localparam int unsigned CW = $clog2(LONG_CYC + 1);

   logic        r_meta;
   logic        r_sync;
   key_state_e  r_state;
   logic [CW-1:0] r_cnt;
   logic        r_long_done;
   logic        r_level;
   logic        r_press;
   logic        r_release;
   logic        r_long;
   logic        r_toggle;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta      <= 1'b1;
         r_sync      <= 1'b1;
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_long_done <= 1'b0;
         r_level     <= 1'b0;
         r_press     <= 1'b0;
         r_release   <= 1'b0;
         r_long      <= 1'b0;
         r_toggle    <= 1'b0;
      end else begin
         r_meta    <= key_n;
         r_sync    <= r_meta;
         r_press   <= 1'b0;
         r_release <= 1'b0;
         r_long    <= 1'b0;
         case (r_state)
            IDLE: begin
               if (!r_sync) begin
                  r_state <= PRESS_WAIT;
                  r_cnt   <= '0;
               end
            end
            PRESS_WAIT: begin
               if (r_sync) begin
                  r_state <= IDLE;
               end else if (r_cnt == CW'(DEB_CYC - 1)) begin
                  r_state  <= HELD;
                  r_press  <= 1'b1;
                  r_level  <= 1'b1;
                  r_toggle <= ~r_toggle;
                  r_cnt    <= '0;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            HELD: begin
               if (r_sync) begin
                  r_state <= RELEASE_WAIT;
                  r_cnt   <= '0;
               end else if (r_cnt != CW'(LONG_CYC)) begin
                  r_cnt <= r_cnt + CW'(1);
                  // long_done keeps a bounced release from re-arming the long pulse
                  if (r_cnt == CW'(LONG_CYC - 1) && !r_long_done) begin
                     r_long      <= 1'b1;
                     r_long_done <= 1'b1;
                  end
               end
            end
            RELEASE_WAIT: begin
               if (!r_sync) begin
                  r_state <= HELD;
                  r_cnt   <= '0;
               end else if (r_cnt == CW'(DEB_CYC - 1)) begin
                  r_state     <= IDLE;
                  r_release   <= 1'b1;
                  r_level     <= 1'b0;
                  r_long_done <= 1'b0;
                  r_cnt       <= '0;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign key_level     = r_level;
   assign press_pulse   = r_press;
   assign release_pulse = r_release;
   assign long_pulse    = r_long;
   assign key_toggle    = r_toggle;

endmodule

// File: rtl/key_debounce.sv
// Debounces NKEYS active-low push-buttons into clean level, pulse and toggle
// outputs; one independent channel per key.
module key_debounce
   import key_pkg::*;
#(
   parameter int unsigned NKEYS       = 2,
   parameter int unsigned CLK_HZ      = 50_000_000,
   parameter int unsigned DEBOUNCE_MS = 20,
   parameter int unsigned LONG_MS     = 1000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NKEYS-1:0] key_n,
   output logic [NKEYS-1:0] key_level,
   output logic [NKEYS-1:0] press_pulse,
   output logic [NKEYS-1:0] release_pulse,
   output logic [NKEYS-1:0] long_pulse,
   output logic [NKEYS-1:0] key_toggle
);

   localparam int unsigned DEB_CYC  = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
   localparam int unsigned LONG_CYC = ms_to_cycles(CLK_HZ, LONG_MS);

   for (genvar g = 0; g < int'(NKEYS); g++) begin : g_ch
      key_debounce_ch #(
         .DEB_CYC  (DEB_CYC),
         .LONG_CYC (LONG_CYC)
      ) u_ch (
         .clk           (clk),
         .rst_n         (rst_n),
         .key_n         (key_n[g]),
         .key_level     (key_level[g]),
         .press_pulse   (press_pulse[g]),
         .release_pulse (release_pulse[g]),
         .long_pulse    (long_pulse[g]),
         .key_toggle    (key_toggle[g])
      );
   end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEB_CYC=4, LONG_CYC=10.
module tb_key_debounce;

   logic       clk;
   logic       rst_n;
   logic [1:0] key_n;
   logic [1:0] key_level;
   logic [1:0] press_pulse;
   logic [1:0] release_pulse;
   logic [1:0] long_pulse;
   logic [1:0] key_toggle;

   int checks;
   int errors;
   int n_press [2];
   int n_rel   [2];
   int n_long  [2];

   key_debounce #(
      .NKEYS       (2),
      .CLK_HZ      (1000),
      .DEBOUNCE_MS (4),
      .LONG_MS     (10)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .key_n         (key_n),
      .key_level     (key_level),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .long_pulse    (long_pulse),
      .key_toggle    (key_toggle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance n clock edges, sampling 1 time unit after each edge and tallying pulses.
   task automatic step(input int n);
      for (int s = 0; s < n; s++) begin
         @(posedge clk);
         #1;
         for (int k = 0; k < 2; k++) begin
            n_press[k] += int'(press_pulse[k]);
            n_rel[k]   += int'(release_pulse[k]);
            n_long[k]  += int'(long_pulse[k]);
         end
      end
   endtask

   task automatic clr();
      for (int k = 0; k < 2; k++) begin
         n_press[k] = 0;
         n_rel[k]   = 0;
         n_long[k]  = 0;
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_level"},  32'(key_level),     32'h0);
      chk({tag, "_press"},  32'(press_pulse),   32'h0);
      chk({tag, "_rel"},    32'(release_pulse), 32'h0);
      chk({tag, "_long"},   32'(long_pulse),    32'h0);
      chk({tag, "_toggle"}, 32'(key_toggle),    32'h0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      clr();
      rst_n  = 1'b0;
      key_n  = 2'b11;

      // Reset state
      step(2);
      chk_all_zero("reset");
      rst_n = 1'b1;
      step(3);
      chk_all_zero("idle");

      // Clean press on key 0, held 20 edges
      clr();
      key_n = 2'b10;
      step(6);
      chk("p0_e6_press", 32'(press_pulse), 32'h0);
      chk("p0_e6_level", 32'(key_level), 32'h0);
      step(1);
      chk("p0_e7_press", 32'(press_pulse), 32'h1);
      chk("p0_e7_level", 32'(key_level), 32'h1);
      chk("p0_e7_toggle", 32'(key_toggle), 32'h1);
      step(1);
      chk("p0_e8_press", 32'(press_pulse), 32'h0);
      step(8);
      chk("p0_e16_long", 32'(long_pulse), 32'h0);
      step(1);
      chk("p0_e17_long", 32'(long_pulse), 32'h1);
      step(1);
      chk("p0_e18_long", 32'(long_pulse), 32'h0);
      step(2);
      key_n = 2'b11;
      step(6);
      chk("r0_e6_rel", 32'(release_pulse), 32'h0);
      chk("r0_e6_level", 32'(key_level), 32'h1);
      step(1);
      chk("r0_e7_rel", 32'(release_pulse), 32'h1);
      chk("r0_e7_level", 32'(key_level), 32'h0);
      chk("r0_e7_toggle", 32'(key_toggle), 32'h1);
      step(1);
      chk("r0_e8_rel", 32'(release_pulse), 32'h0);
      chk("p0_npress", 32'(n_press[0]), 32'd1);
      chk("p0_nlong", 32'(n_long[0]), 32'd1);
      chk("p0_nrel", 32'(n_rel[0]), 32'd1);

      // Press bounce: low 2, high 1, low 2, then high
      clr();
      key_n[0] = 1'b0; step(2);
      key_n[0] = 1'b1; step(1);
      key_n[0] = 1'b0; step(2);
      key_n[0] = 1'b1; step(10);
      chk("bnc_npress", 32'(n_press[0]), 32'd0);
      chk("bnc_nrel", 32'(n_rel[0]), 32'd0);
      chk("bnc_level", 32'(key_level), 32'h0);

      // Hold past long, then a 2-cycle release bounce
      clr();
      key_n[0] = 1'b0;
      step(20);
      chk("hb_npress", 32'(n_press[0]), 32'd1);
      chk("hb_nlong", 32'(n_long[0]), 32'd1);
      chk("hb_toggle", 32'(key_toggle), 32'h0);
      clr();
      key_n[0] = 1'b1; step(2);
      key_n[0] = 1'b0; step(15);
      chk("hb_bnc_nrel", 32'(n_rel[0]), 32'd0);
      chk("hb_bnc_nlong", 32'(n_long[0]), 32'd0);
      chk("hb_bnc_level", 32'(key_level), 32'h1);
      key_n[0] = 1'b1;
      step(10);
      chk("hb_nrel", 32'(n_rel[0]), 32'd1);
      chk("hb_level", 32'(key_level), 32'h0);

      // Two presses on key 1
      clr();
      key_n[1] = 1'b0; step(8);
      chk("k1_tog1", 32'(key_toggle[1]), 32'h1);
      key_n[1] = 1'b1; step(8);
      chk("k1_lvl_rel", 32'(key_level[1]), 32'h0);
      key_n[1] = 1'b0; step(8);
      chk("k1_tog2", 32'(key_toggle[1]), 32'h0);
      key_n[1] = 1'b1; step(8);
      chk("k1_npress", 32'(n_press[1]), 32'd2);
      chk("k1_nrel", 32'(n_rel[1]), 32'd2);
      chk("k1_k0_npress", 32'(n_press[0]), 32'd0);

      // Simultaneous press on both keys
      clr();
      key_n = 2'b00;
      step(6);
      chk("sim_e6_press", 32'(press_pulse), 32'h0);
      step(1);
      chk("sim_e7_press", 32'(press_pulse), 32'h3);
      chk("sim_e7_level", 32'(key_level), 32'h3);
      chk("sim_e7_toggle", 32'(key_toggle), 32'h3);
      key_n = 2'b11;
      step(8);
      chk("sim_level_rel", 32'(key_level), 32'h0);

      // Reset during PRESS_WAIT with key 0 still held afterwards
      key_n = 2'b10;
      step(4);
      rst_n = 1'b0;
      #1;
      chk_all_zero("rst_pw");
      step(2);
      rst_n = 1'b1;
      step(6);
      chk("rst_pw_e6_press", 32'(press_pulse), 32'h0);
      step(1);
      chk("rst_pw_e7_press", 32'(press_pulse), 32'h1);
      chk("rst_pw_e7_toggle", 32'(key_toggle), 32'h1);

      // Reset during HELD with key 0 still held afterwards
      step(3);
      rst_n = 1'b0;
      #1;
      chk_all_zero("rst_held");
      step(2);
      rst_n = 1'b1;
      step(6);
      chk("rst_h_e6_press", 32'(press_pulse), 32'h0);
      step(1);
      chk("rst_h_e7_press", 32'(press_pulse), 32'h1);
      chk("rst_h_e7_level", 32'(key_level), 32'h1);
      key_n = 2'b11;
      step(10);
      chk("end_level", 32'(key_level), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
